spi_periph_bridge: RTL
======================

# spi_periph_bridge

Parametrised successor to the single-peripheral SPI test harness bridge. It is an SPI mode-0 target that decodes framed register transactions and drives up to `NUM_CH` TinyQV-style peripherals: write/read strobes, byte/half/word width, auto-increment bursts, and a read wait window with error flagging. It sits between the already-synchronised SPI pins and the peripheral instances in the test wrapper.

## Interface
Parameters:
- `NUM_CH`, 4: number of peripheral channels, 1..8; `CH_W = max(1, clog2(NUM_CH))`.
- `ADDR_W`, 6: peripheral register address width.
- `DATA_W`, 32: register width, fixed at 32 in this generation; other values are rejected at elaboration.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `spi_cs_n`, `spi_clk`, `spi_mosi`  in  1 each  SPI inputs, already synchronised to `clk`.
- `spi_miso`  out  1  serial read data.
- `address`  out  ADDR_W  register address, shared by all channels.
- `data_in`  out  32  write data, shared by all channels.
- `data_write_n`  out  2*NUM_CH  per-channel write strobe, `{ch*2+1:ch*2}`; 11 = idle.
- `data_read_n`  out  2*NUM_CH  per-channel read strobe; same encoding.
- `data_out`  in  32*NUM_CH  per-channel read data.
- `data_ready`  in  NUM_CH  per-channel read-data-valid.
- `user_interrupt`  in  NUM_CH  per-channel interrupts.
- `irq_any`  out  1  OR of all `user_interrupt` bits, registered.
- `err`  out  1  sticky read-timeout or bad-channel flag; cleared by reset or by a write to channel `NUM_CH-1`, address all-ones.

## Operation
- All SPI fields are MSB-first. MOSI is sampled on the `spi_clk` rising edge, and MISO is updated after the falling edge. Both edges are detected from the registered previous value.
- Header is `1+2+CH_W+ADDR_W` bits: `rw` (1 = write), `txn[1:0]` (00 byte, 01 half, 10 word, 11 reserved and treated as word), `ch`, `addr`.
- Data phase is `NB` = 1, 2 or 4 bytes, per `txn`. Data are the low `8*NB` bits, most significant byte first. Unused upper bits are zero in both directions.
- FSM states: IDLE → HDR → (WDATA | RWAIT → RDATA) → back to WDATA/RWAIT for a burst, or IDLE on CS deassert.
- Write: when the last data bit of a phase arrives, for exactly one cycle:
  - `data_write_n[ch]` = `txn`;
  - `address` = current address;
  - `data_in` = the assembled word.
- Read: when the header completes (and, in a burst, when each RDATA phase completes), for exactly one cycle:
  - `data_read_n[ch]` = `txn`;
  - `address` = current address.
  - RWAIT then consumes 8 dummy SPI clocks. The first `data_ready[ch]` pulse in RWAIT captures `data_out[ch]`, masked to `8*NB` bits.
  - If the dummy byte ends without a capture, the returned data are 0 and `err` is set.
- Burst: while CS stays low after a data phase, the address advances by `NB`, wrapping modulo `2^ADDR_W`, and another phase follows.
- `ch >= NUM_CH`: no strobe is issued, reads return 0, and `err` is set.
- CS deassert in any state:
  - return to IDLE next cycle;
  - drop any partial write (no strobe);
  - a read already strobed completes on the peripheral side, but its data are discarded.
- Reset: FSM to IDLE; `spi_miso` = 0; all strobes = 11; `address` = 0; `data_in` = 0; `err` = 0; `irq_any` = 0.

## Timing
- Write strobe is asserted 1 `clk` cycle after the `clk` cycle that detects the final data-bit rising edge. It lasts exactly 1 cycle.
- Read strobe is asserted 1 cycle after the final header-bit edge. It lasts exactly 1 cycle.
- `data_ready` arriving in the same cycle as the read strobe is accepted.
- `data_ready` arriving after RWAIT ends is ignored.
- At most one channel's strobe pair is non-11 in any cycle.
- Minimum `spi_clk` period is 8 `clk` cycles (each phase at least 4 cycles).
- `irq_any` has 1 cycle of latency.

## Structure
- Package `spi_bridge_pkg` holds:
  - the txn encodings and `STROBE_IDLE = 2'b11`;
  - the FSM state enum;
  - the function `txn_bytes(txn)`.
- One sub-module, `spi_shift_core`:
  - SPI edge detection;
  - bit counter;
  - MOSI shift-in and MISO shift-out;
  - signals "frame byte done" to the top-level FSM.

## Test plan
- Write, word, ch1, addr 0x05, data 0xDEADBEEF → `data_write_n[3:2]` = 10 for 1 cycle; `address` = 0x05; `data_in` = 0xDEADBEEF; other channels stay 11.
- Read, byte, ch0, addr 0x10; peripheral returns 0x123456A5 with `data_ready` 3 cycles after the strobe → MISO returns 0xA5; `err` = 0.
- Read, half, ch2, with `data_ready` never asserted → returns 0x0000; `err` = 1 until the clear-write or reset.
- Burst write, half, ch0, addr 0x3E, 3 phases → writes at 0x3E, 0x00, 0x02.
- CS raised after 20 of 32 write-data bits → no strobe; the next frame decodes correctly.
- `rst` asserted mid-RWAIT → all outputs at reset values next cycle; a subsequent write of 0x5A succeeds.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI peripheral bridge.
//   - transaction-width encodings and the idle strobe code
//   - FSM state enum
//   - helpers: txn_bytes (data-phase length), txn_mask (valid data bits),
//     align_msb (left-justify a value for MSB-first shift-out)
package spi_bridge_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] TXN_BYTE    = 2'b00;
    localparam logic [1:0] TXN_HALF    = 2'b01;
    localparam logic [1:0] TXN_WORD    = 2'b10;
    localparam logic [1:0] TXN_RSVD    = 2'b11;
    localparam logic [1:0] STROBE_IDLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RDATA = 3'd4
    } state_e;

    // Reserved encoding behaves as a word for data length.
    function automatic logic [2:0] txn_bytes(input logic [1:0] txn);
        case (txn)
            TXN_BYTE: return 3'd1;
            TXN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [BUS_W-1:0] txn_mask(input logic [1:0] txn);
        case (txn)
            TXN_BYTE: return 32'h0000_00FF;
            TXN_HALF: return 32'h0000_FFFF;
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Puts the most significant transmitted bit at position 31.
    function automatic logic [BUS_W-1:0] align_msb(input logic [BUS_W-1:0] val,
                                                   input logic [1:0]       txn);
        case (txn)
            TXN_BYTE: return {val[7:0], 24'h0};
            TXN_HALF: return {val[15:0], 16'h0};
            default:  return val;
        endcase
    endfunction

endpackage

// File: rtl/spi_shift_core.sv
// SPI mode-0 bit engine for the peripheral bridge.
//   spi_cs_n/spi_clk/spi_mosi : synchronised SPI inputs
//   field_len   : length in bits of the field currently being received
//   field_done  : combinational pulse in the cycle that detects the last
//                 rising edge of a field; rx_next then holds the whole field
//   rx_next     : shift register contents including the bit sampled this cycle
//   tx_load/tx_word : load a left-justified word for shift-out
//   tx_shift_en : MISO advances one bit on each spi_clk falling edge
//   spi_miso    : registered serial output
module spi_shift_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic [7:0]  field_len,
    input  logic        tx_load,
    input  logic [31:0] tx_word,
    input  logic        tx_shift_en,
    output logic        field_done,
    output logic [31:0] rx_next,
    output logic        spi_miso
);

    logic        sclk_q, sclk_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        rise, fall;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; an unassigned path would infer a latch.
    always_comb begin
        sclk_d     = spi_clk;
        rise       = spi_clk & ~sclk_q & ~spi_cs_n;
        fall       = ~spi_clk & sclk_q & ~spi_cs_n;
        rx_next    = {rx_q[30:0], spi_mosi};
        field_done = rise && (cnt_q == field_len - 8'd1);
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso_d     = miso_q;

        if (spi_cs_n) begin
            cnt_d = '0;
        end else if (rise) begin
            rx_d  = rx_next;
            cnt_d = field_done ? 8'd0 : cnt_q + 8'd1;
        end

        if (tx_load) begin
            tx_d = tx_word;
        end else if (tx_shift_en && fall) begin
            miso_d = tx_q[31];
            tx_d   = {tx_q[30:0], 1'b0};
        end
    end

    // NOTE: flops are written only with <= so every always_ff reads the
    // pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 1'b0;
            cnt_q  <= '0;
            rx_q   <= '0;
            tx_q   <= '0;
            miso_q <= 1'b0;
        end else begin
            sclk_q <= sclk_d;
            cnt_q  <= cnt_d;
            rx_q   <= rx_d;
            tx_q   <= tx_d;
            miso_q <= miso_d;
        end
    end

    assign spi_miso = miso_q;

endmodule

// File: rtl/spi_periph_bridge.sv
// SPI mode-0 target that decodes framed register transactions and drives
// up to NUM_CH TinyQV-style peripherals.
//   clk, rst          : clock, synchronous active-high reset
//   spi_*             : synchronised SPI pins (spi_miso is the serial reply)
//   address, data_in  : shared register address / write data
//   data_write_n/data_read_n : per-channel 2-bit strobes, 11 = idle
//   data_out, data_ready     : per-channel read data and valid
//   user_interrupt, irq_any  : per-channel interrupts and their registered OR
//   err               : sticky read-timeout / bad-channel flag
module spi_periph_bridge
    import spi_bridge_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cs_n,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_W-1:0]     address,
    output logic [31:0]           data_in,
    output logic [2*NUM_CH-1:0]   data_write_n,
    output logic [2*NUM_CH-1:0]   data_read_n,
    input  logic [32*NUM_CH-1:0]  data_out,
    input  logic [NUM_CH-1:0]     data_ready,
    input  logic [NUM_CH-1:0]     user_interrupt,
    output logic                  irq_any,
    output logic                  err
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HDR_W = 3 + CH_W + ADDR_W;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("spi_periph_bridge: DATA_W must be 32");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("spi_periph_bridge: NUM_CH must be 1..8");
    end
    if (HDR_W > 32) begin : g_bad_addr_w
        $error("spi_periph_bridge: header does not fit the shift register");
    end

    state_e                state_q, state_d;
    logic [1:0]            txn_q, txn_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  cap_q, cap_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic [31:0]           data_in_q, data_in_d;
    logic [2*NUM_CH-1:0]   wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic                  err_q, err_d, irq_q, irq_d;

    logic                  field_done, tx_load;
    logic [7:0]            field_len;
    logic [31:0]           rx_next, tx_word;
    logic [HDR_W-1:0]      hdr;
    logic                  hdr_rw, hdr_ch_ok, ch_ok;
    logic [1:0]            hdr_txn;
    logic [CH_W-1:0]       hdr_ch;
    logic [ADDR_W-1:0]     hdr_addr, addr_next;
    logic [2:0]            nb;

    spi_shift_core u_core (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .field_len   (field_len),
        .tx_load     (tx_load),
        .tx_word     (tx_word),
        .tx_shift_en (state_q == ST_RDATA),
        .field_done  (field_done),
        .rx_next     (rx_next),
        .spi_miso    (spi_miso)
    );

    always_comb begin
        hdr       = rx_next[HDR_W-1:0];
        hdr_rw    = hdr[HDR_W-1];
        hdr_txn   = hdr[HDR_W-2 -: 2];
        hdr_ch    = hdr[ADDR_W +: CH_W];
        hdr_addr  = hdr[ADDR_W-1:0];
        hdr_ch_ok = 32'(hdr_ch) < 32'(NUM_CH);
        ch_ok     = 32'(ch_q) < 32'(NUM_CH);
        nb        = txn_bytes(txn_q);
        addr_next = addr_q + ADDR_W'(nb);

        case (state_q)
            ST_IDLE, ST_HDR: field_len = 8'(HDR_W);
            ST_RWAIT:        field_len = 8'd8;
            default:         field_len = {2'b00, nb, 3'b000};
        endcase

        state_d   = state_q;
        txn_d     = txn_q;
        ch_d      = ch_q;
        addr_d    = addr_q;
        cap_d     = cap_q;
        rdata_d   = rdata_q;
        address_d = address_q;
        data_in_d = data_in_q;
        wr_n_d    = '1;
        rd_n_d    = '1;
        err_d     = err_q;
        irq_d     = |user_interrupt;
        tx_load   = 1'b0;
        tx_word   = '0;

        if (spi_cs_n) begin
            // Partial writes are dropped; a pending read's data are discarded.
            state_d = ST_IDLE;
            cap_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HDR;
                ST_HDR: if (field_done) begin
                    txn_d  = hdr_txn;
                    ch_d   = hdr_ch;
                    addr_d = hdr_addr;
                    if (!hdr_ch_ok) err_d = 1'b1;
                    if (hdr_rw) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RWAIT;
                        cap_d   = 1'b0;
                        rdata_d = '0;
                        if (hdr_ch_ok) begin
                            // Reserved txn is passed through as-is (reads as idle).
                            rd_n_d[2*hdr_ch +: 2] = hdr_txn;
                            address_d             = hdr_addr;
                        end
                    end
                end
                ST_WDATA: if (field_done) begin
                    if (ch_ok) begin
                        wr_n_d[2*ch_q +: 2] = txn_q;
                        address_d           = addr_q;
                        data_in_d           = rx_next & txn_mask(txn_q);
                        if (32'(ch_q) == 32'(NUM_CH - 1) && (&addr_q)) err_d = 1'b0;
                    end
                    addr_d = addr_next;
                end
                ST_RWAIT: begin
                    // Only the first ready pulse inside the dummy byte is taken.
                    if (!cap_q && ch_ok && data_ready[ch_q]) begin
                        cap_d   = 1'b1;
                        rdata_d = data_out[32*ch_q +: 32] & txn_mask(txn_q);
                    end
                    if (field_done) begin
                        state_d = ST_RDATA;
                        tx_load = 1'b1;
                        tx_word = align_msb(rdata_d, txn_q);
                        if (!cap_d) err_d = 1'b1;
                    end
                end
                ST_RDATA: if (field_done) begin
                    state_d = ST_RWAIT;
                    addr_d  = addr_next;
                    cap_d   = 1'b0;
                    rdata_d = '0;
                    if (ch_ok) begin
                        rd_n_d[2*ch_q +: 2] = txn_q;
                        address_d           = addr_next;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            txn_q     <= TXN_BYTE;
            ch_q      <= '0;
            addr_q    <= '0;
            cap_q     <= 1'b0;
            rdata_q   <= '0;
            address_q <= '0;
            data_in_q <= '0;
            wr_n_q    <= {NUM_CH{STROBE_IDLE}};
            rd_n_q    <= {NUM_CH{STROBE_IDLE}};
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            txn_q     <= txn_d;
            ch_q      <= ch_d;
            addr_q    <= addr_d;
            cap_q     <= cap_d;
            rdata_q   <= rdata_d;
            address_q <= address_d;
            data_in_q <= data_in_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
        end
    end

    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = wr_n_q;
    assign data_read_n  = rd_n_q;
    assign err          = err_q;
    assign irq_any      = irq_q;

endmodule
